mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the execute ALU result as the effective address and register B as store data.
- Runs a request/acknowledge transaction on the data-memory port, aligns and sign-extends load data, and stalls the pipeline while a transaction is outstanding.
- Non-memory instructions pass the ALU result through with zero added latency.

Parameters:
- TIMEOUT, 255: maximum BUSY cycles without ack before the access is aborted (1..65535).

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- ex_mem_valid_inst  in  1  instruction in this stage is valid
- ex_mem_rd_mem  in  1  instruction is a load
- ex_mem_wr_mem  in  1  instruction is a store
- ex_mem_alu_result  in  32  effective address, or ALU result for non-memory instructions
- ex_mem_regb  in  32  store data
- ex_mem_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem2proc_ack  in  1  memory completes the current request
- mem2proc_data  in  32  word read data, valid with ack
- proc2mem_req  out  1  request outstanding (registered)
- proc2mem_we  out  1  1 = write (registered)
- proc2mem_addr  out  32  word address, bits[1:0] = 0 (registered)
- proc2mem_data  out  32  lane-replicated store data (registered)
- proc2mem_be  out  4  byte enables (registered)
- mem_result_out  out  32  load data or ALU pass-through (combinational)
- mem_stall  out  1  hold upstream registers (combinational)
- mem_valid_out  out  1  result valid for MEM/WB capture this cycle
- mem_fault  out  1  misaligned/illegal access, or timeout

Behaviour:
- Reset: state IDLE; wait counter 0; all registered outputs 0. Reset wins over ack in the same cycle; a request is dropped at that edge with no result and no fault.
- mem_op = ex_mem_valid_inst & (ex_mem_rd_mem | ex_mem_wr_mem).
- bad (combinational) is 1 for any of:
  - rd and wr both set;
  - funct3 not in {000, 001, 010, 100, 101} (stores: {000, 001, 010} only);
  - H/HU with addr[0] = 1;
  - W with addr[1:0] != 0.

IDLE state:
- mem_op & ~bad: mem_stall = 1, mem_valid_out = 0. At the clock edge: latch req = 1, we = wr, addr = {alu[31:2], 2'b00}, be, data; go to BUSY; counter = 0.
  - SB: be = 0001 << addr[1:0]; data = byte replicated ×4.
  - SH: be = 0011 if addr[1] = 0, else 1100; data = halfword replicated ×2.
  - SW: be = 1111; data = regb.
  - Loads: be = 1111; data = 0.
- mem_op & bad: no request; mem_stall = 0; mem_fault = 1; mem_valid_out = 1; mem_result_out = 0.
- Not mem_op: mem_result_out = ex_mem_alu_result; mem_stall = 0; mem_valid_out = ex_mem_valid_inst.

BUSY state:
- Request outputs are held stable and inputs are not re-sampled. Upstream holds its inputs because of the stall.
- ack = 0:
  - mem_stall = 1.
  - If counter == TIMEOUT-1: go to IDLE, req = 0, mem_fault = 1 and mem_valid_out = 1 for this cycle, mem_stall = 0.
  - Otherwise counter increments.
- ack = 1:
  - mem_stall = 0, mem_valid_out = 1.
  - At the edge: req = 0, go to IDLE.
  - Upstream advances at the same edge, so the instruction is never re-issued.
- Load formatting, with offset = addr[1:0] latched from the request:
  - byte = mem2proc_data[8*off +: 8]; B sign-extends, BU zero-extends.
  - half = mem2proc_data[16*off[1] +: 16]; H sign-extends, HU zero-extends.
  - W passes the word unchanged.
- Stores: mem_result_out = 0.
- Latency:
  - memory op: 1 accept cycle + N ≥ 1 BUSY cycles; fastest is ack in the first BUSY cycle = 2 cycles;
  - non-memory instruction: 0 extra cycles.
- Store and load format state (funct3, offset) is latched in BUSY so that upstream changes cannot corrupt the result.
- Ack received while in IDLE is ignored.

Test Plan:
- Reset, then ALU pass-through: valid = 1, rd = wr = 0, alu = 0x1234 → mem_result_out = 0x1234, mem_stall = 0, mem_valid_out = 1, req = 0.
- LB at address 0x1003; memory returns 0x80FF_FF00 with ack on the 3rd BUSY cycle:
  - mem_stall = 1 for 3 cycles (accept + 2 BUSY);
  - in the ack cycle mem_result_out = 0xFFFF_FF80, proc2mem_addr = 0x1000, be = 1111.
- SH of regb = 0x0000_ABCD at 0x2002 with ack on the 1st BUSY cycle:
  - proc2mem_we = 1, be = 1100, data = 0xABCD_ABCD;
  - stall is 1 only in the accept cycle; mem_result_out = 0.
- Misaligned LW at 0x3001 → no req; mem_fault = 1; mem_valid_out = 1; mem_result_out = 0; mem_stall = 0.
- Timeout with TIMEOUT = 4 and ack never asserted:
  - req high for 4 cycles;
  - fault and valid pulse in the 4th BUSY cycle; state returns to IDLE; the next instruction is accepted.
- Reset mid-operation: rst asserted while BUSY and ack = 1 in the same cycle → next cycle req = 0, addr/be/data = 0, mem_valid_out = 0, state IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: drives a req/ack data-memory port from the execute result and formats load data.
// Latency: non-memory ops 0 cycles; memory ops 1 accept cycle + N>=1 BUSY cycles (ack-terminated or timeout).
// Backpressure: mem_stall holds upstream from accept until ack/timeout; request outputs are registered and stable while BUSY.
//
// Ports: clk/rst (sync, active-high); ex_mem_* instruction inputs from execute;
// mem2proc_ack/data memory response; proc2mem_* registered request; mem_result_out,
// mem_stall, mem_valid_out, mem_fault toward MEM/WB and the pipeline control.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_valid_inst,
    input  logic        ex_mem_rd_mem,
    input  logic        ex_mem_wr_mem,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_regb,
    input  logic [2:0]  ex_mem_funct3,
    input  logic        mem2proc_ack,
    input  logic [31:0] mem2proc_data,
    output logic        proc2mem_req,
    output logic        proc2mem_we,
    output logic [31:0] proc2mem_addr,
    output logic [31:0] proc2mem_data,
    output logic [3:0]  proc2mem_be,
    output logic [31:0] mem_result_out,
    output logic        mem_stall,
    output logic        mem_valid_out,
    output logic        mem_fault
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;

    logic        mem_op;
    logic        bad;
    logic        f3_legal;
    logic        timeout_hit;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    assign mem_op = ex_mem_valid_inst & (ex_mem_rd_mem | ex_mem_wr_mem);

    // BU/HU only make sense for loads; stores accept B/H/W.
    always_comb begin
        f3_legal = 1'b0;
        case (ex_mem_funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = ~ex_mem_wr_mem;
            default:                f3_legal = 1'b0;
        endcase
    end

    assign bad = (ex_mem_rd_mem & ex_mem_wr_mem)
               | ~f3_legal
               | ((ex_mem_funct3[1:0] == 2'b01) & ex_mem_alu_result[0])
               | ((ex_mem_funct3[1:0] == 2'b10) & (|ex_mem_alu_result[1:0]));

    assign timeout_hit = (state_q == BUSY) & ~mem2proc_ack & (cnt_q == TIMEOUT_LAST);

    // Load formatting uses the offset/size latched at accept, never the live inputs.
    assign ld_byte = mem2proc_data[{off_q, 3'b000} +: 8];
    assign ld_half = mem2proc_data[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        case (f3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt = {24'h0, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_fmt = {16'h0, ld_half};
            default: ld_fmt = mem2proc_data;
        endcase
    end

    // Combinational handshake toward the pipeline.
    always_comb begin
        mem_result_out = 32'h0;
        mem_stall      = 1'b0;
        mem_valid_out  = 1'b0;
        mem_fault      = 1'b0;
        if (state_q == IDLE) begin
            if (!mem_op) begin
                mem_result_out = ex_mem_alu_result;
                mem_valid_out  = ex_mem_valid_inst;
            end else if (bad) begin
                mem_fault     = 1'b1;
                mem_valid_out = 1'b1;
            end else begin
                mem_stall = 1'b1;
            end
        end else begin
            if (mem2proc_ack) begin
                mem_valid_out  = 1'b1;
                mem_result_out = we_q ? 32'h0 : ld_fmt;
            end else if (timeout_hit) begin
                mem_fault     = 1'b1;
                mem_valid_out = 1'b1;
            end else begin
                mem_stall = 1'b1;
            end
        end
    end

    // Next-state and request latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        f3_d    = f3_q;
        off_d   = off_q;
        if (state_q == IDLE) begin
            if (mem_op && !bad) begin
                state_d = BUSY;
                cnt_d   = 16'h0;
                req_d   = 1'b1;
                we_d    = ex_mem_wr_mem;
                addr_d  = {ex_mem_alu_result[31:2], 2'b00};
                f3_d    = ex_mem_funct3;
                off_d   = ex_mem_alu_result[1:0];
                be_d    = 4'b1111;
                data_d  = 32'h0;
                if (ex_mem_wr_mem) begin
                    case (ex_mem_funct3[1:0])
                        2'b00: begin
                            be_d   = 4'b0001 << ex_mem_alu_result[1:0];
                            data_d = {4{ex_mem_regb[7:0]}};
                        end
                        2'b01: begin
                            be_d   = ex_mem_alu_result[1] ? 4'b1100 : 4'b0011;
                            data_d = {2{ex_mem_regb[15:0]}};
                        end
                        default: data_d = ex_mem_regb;
                    endcase
                end
            end
        end else begin
            if (mem2proc_ack || timeout_hit) begin
                state_d = IDLE;
                req_d   = 1'b0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'h0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            be_q    <= 4'h0;
            f3_q    <= 3'h0;
            off_q   <= 2'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
        end
    end

    assign proc2mem_req  = req_q;
    assign proc2mem_we   = we_q;
    assign proc2mem_addr = addr_q;
    assign proc2mem_data = data_q;
    assign proc2mem_be   = be_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_valid_inst;
    logic        ex_mem_rd_mem;
    logic        ex_mem_wr_mem;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_regb;
    logic [2:0]  ex_mem_funct3;
    logic        mem2proc_ack;
    logic [31:0] mem2proc_data;
    logic        proc2mem_req;
    logic        proc2mem_we;
    logic [31:0] proc2mem_addr;
    logic [31:0] proc2mem_data;
    logic [3:0]  proc2mem_be;
    logic [31:0] mem_result_out;
    logic        mem_stall;
    logic        mem_valid_out;
    logic        mem_fault;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_valid_inst(ex_mem_valid_inst), .ex_mem_rd_mem(ex_mem_rd_mem),
        .ex_mem_wr_mem(ex_mem_wr_mem), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_regb(ex_mem_regb), .ex_mem_funct3(ex_mem_funct3),
        .mem2proc_ack(mem2proc_ack), .mem2proc_data(mem2proc_data),
        .proc2mem_req(proc2mem_req), .proc2mem_we(proc2mem_we),
        .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
        .proc2mem_be(proc2mem_be), .mem_result_out(mem_result_out),
        .mem_stall(mem_stall), .mem_valid_out(mem_valid_out), .mem_fault(mem_fault)
    );

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic v, input logic rd, input logic wr,
                            input logic [31:0] alu, input logic [31:0] rb, input logic [2:0] f3);
        ex_mem_valid_inst = v;
        ex_mem_rd_mem     = rd;
        ex_mem_wr_mem     = wr;
        ex_mem_alu_result = alu;
        ex_mem_regb       = rb;
        ex_mem_funct3     = f3;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem2proc_ack = 1'b0;
        mem2proc_data = 32'h0;
        set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        step(); step();
        #1;
        checks++;
        if ({proc2mem_req, proc2mem_we, proc2mem_be} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got req/we/be=%b expected 000000", {proc2mem_req, proc2mem_we, proc2mem_be});
        end
        checks++;
        if ({proc2mem_addr, proc2mem_data} !== 64'h0) begin
            failures++;
            $display("FAIL reset_addr_data: got %h expected 0", {proc2mem_addr, proc2mem_data});
        end
        checks++;
        if ({mem_stall, mem_valid_out, mem_fault} !== 3'b000) begin
            failures++;
            $display("FAIL reset_hs: got stall/valid/fault=%b expected 000", {mem_stall, mem_valid_out, mem_fault});
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        step();
        mem2proc_ack = 1'b1;  // stray ack in IDLE must be ignored
        set_inst(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF, 3'b010);
        checks++;
        if (mem_result_out !== 32'h0000_1234) begin
            failures++;
            $display("FAIL pass_result: got %h expected 00001234", mem_result_out);
        end
        checks++;
        if ({mem_stall, mem_valid_out, mem_fault, proc2mem_req} !== 4'b0100) begin
            failures++;
            $display("FAIL pass_hs: got stall/valid/fault/req=%b expected 0100", {mem_stall, mem_valid_out, mem_fault, proc2mem_req});
        end
        step();
        checks++;
        if (proc2mem_req !== 1'b0) begin
            failures++;
            $display("FAIL pass_idle_ack: got req=%b expected 0", proc2mem_req);
        end
        mem2proc_ack = 1'b0;
        set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    task automatic test_lb();
        int stalls = 0;
        step();
        set_inst(1'b1, 1'b1, 1'b0, 32'h0000_1003, 32'h0, 3'b000);
        if (mem_stall === 1'b1) stalls++;
        checks++;
        if ({mem_valid_out, proc2mem_req} !== 2'b00) begin
            failures++;
            $display("FAIL lb_accept: got valid/req=%b expected 00", {mem_valid_out, proc2mem_req});
        end
        for (int c = 0; c < 2; c++) begin
            step();
            if (mem_stall === 1'b1) stalls++;
        end
        step();
        mem2proc_ack = 1'b1;
        mem2proc_data = 32'h80FF_FF00;
        #1;
        if (mem_stall === 1'b1) stalls++;
        checks++;
        if (stalls != 3) begin
            failures++;
            $display("FAIL lb_stall_cycles: got %0d expected 3", stalls);
        end
        checks++;
        if (mem_result_out !== 32'hFFFF_FF80 || mem_valid_out !== 1'b1) begin
            failures++;
            $display("FAIL lb_result: got %h valid=%b expected ffffff80 valid=1", mem_result_out, mem_valid_out);
        end
        checks++;
        if (proc2mem_addr !== 32'h0000_1000 || proc2mem_be !== 4'b1111 || proc2mem_req !== 1'b1 || proc2mem_we !== 1'b0) begin
            failures++;
            $display("FAIL lb_req: got addr=%h be=%b req=%b we=%b expected 00001000 1111 1 0",
                     proc2mem_addr, proc2mem_be, proc2mem_req, proc2mem_we);
        end
        step();
        mem2proc_ack = 1'b0;
        set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        checks++;
        if (proc2mem_req !== 1'b0) begin
            failures++;
            $display("FAIL lb_done: got req=%b expected 0", proc2mem_req);
        end
    endtask

    task automatic test_stores();
        logic [31:0] st_alu [2] = '{32'h0000_2002, 32'h0000_6001};
        logic [31:0] st_rb  [2] = '{32'h0000_ABCD, 32'h1234_565A};
        logic [2:0]  st_f3  [2] = '{3'b001, 3'b000};
        logic [3:0]  exp_be [2] = '{4'b1100, 4'b0010};
        logic [31:0] exp_dt [2] = '{32'hABCD_ABCD, 32'h5A5A_5A5A};
        logic [31:0] exp_ad [2] = '{32'h0000_2000, 32'h0000_6000};
        for (int i = 0; i < 2; i++) begin
            step();
            set_inst(1'b1, 1'b0, 1'b1, st_alu[i], st_rb[i], st_f3[i]);
            checks++;
            if (mem_stall !== 1'b1) begin
                failures++;
                $display("FAIL st%0d_accept_stall: got %b expected 1", i, mem_stall);
            end
            step();
            mem2proc_ack = 1'b1;
            mem2proc_data = 32'hFFFF_FFFF;
            #1;
            checks++;
            if (proc2mem_we !== 1'b1 || proc2mem_be !== exp_be[i] || proc2mem_data !== exp_dt[i] || proc2mem_addr !== exp_ad[i]) begin
                failures++;
                $display("FAIL st%0d_req: got we=%b be=%b data=%h addr=%h expected 1 %b %h %h",
                         i, proc2mem_we, proc2mem_be, proc2mem_data, proc2mem_addr, exp_be[i], exp_dt[i], exp_ad[i]);
            end
            checks++;
            if (mem_stall !== 1'b0 || mem_valid_out !== 1'b1 || mem_result_out !== 32'h0) begin
                failures++;
                $display("FAIL st%0d_ack: got stall=%b valid=%b result=%h expected 0 1 0",
                         i, mem_stall, mem_valid_out, mem_result_out);
            end
            step();
            mem2proc_ack = 1'b0;
            set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        end
    endtask

    task automatic test_load_formats();
        logic [31:0] a   [5] = '{32'h0000_5001, 32'h0000_5002, 32'h0000_5002, 32'h0000_5000, 32'h0000_5000};
        logic [2:0]  f   [5] = '{3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
        logic [31:0] d   [5] = '{32'h1234_8056, 32'h8001_0000, 32'h8001_0000, 32'hDEAD_BEEF, 32'h0000_007F};
        logic [31:0] exp [5] = '{32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'hDEAD_BEEF, 32'h0000_007F};
        for (int i = 0; i < 5; i++) begin
            step();
            set_inst(1'b1, 1'b1, 1'b0, a[i], 32'h0, f[i]);
            step();
            // Disturb the upstream inputs: the latched size/offset must be used.
            set_inst(1'b1, 1'b1, 1'b0, 32'h0000_0003, 32'h0, 3'b010);
            mem2proc_ack = 1'b1;
            mem2proc_data = d[i];
            #1;
            checks++;
            if (mem_result_out !== exp[i] || mem_valid_out !== 1'b1) begin
                failures++;
                $display("FAIL ld_fmt%0d: got %h valid=%b expected %h valid=1", i, mem_result_out, mem_valid_out, exp[i]);
            end
            step();
            mem2proc_ack = 1'b0;
            set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        end
    endtask

    task automatic test_bad_access();
        step();
        set_inst(1'b1, 1'b1, 1'b0, 32'h0000_3001, 32'h0, 3'b010);
        checks++;
        if ({mem_fault, mem_valid_out, mem_stall} !== 3'b110 || mem_result_out !== 32'h0) begin
            failures++;
            $display("FAIL lw_misaligned: got fault/valid/stall=%b result=%h expected 110 0",
                     {mem_fault, mem_valid_out, mem_stall}, mem_result_out);
        end
        step();
        checks++;
        if (proc2mem_req !== 1'b0) begin
            failures++;
            $display("FAIL lw_misaligned_req: got %b expected 0", proc2mem_req);
        end
        set_inst(1'b1, 1'b0, 1'b1, 32'h0000_3000, 32'h0, 3'b100);  // SBU is not a store
        checks++;
        if ({mem_fault, mem_valid_out, mem_stall} !== 3'b110) begin
            failures++;
            $display("FAIL st_bad_f3: got fault/valid/stall=%b expected 110", {mem_fault, mem_valid_out, mem_stall});
        end
        set_inst(1'b1, 1'b1, 1'b1, 32'h0000_3000, 32'h0, 3'b010);
        checks++;
        if ({mem_fault, mem_stall} !== 2'b10) begin
            failures++;
            $display("FAIL rd_and_wr: got fault/stall=%b expected 10", {mem_fault, mem_stall});
        end
        step();
        checks++;
        if (proc2mem_req !== 1'b0) begin
            failures++;
            $display("FAIL bad_req: got %b expected 0", proc2mem_req);
        end
        set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        step();
        set_inst(1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 3'b010);
        for (int c = 1; c <= 4; c++) begin
            step();
            if (proc2mem_req === 1'b1) req_cycles++;
            checks++;
            if (c < 4 && {mem_fault, mem_valid_out, mem_stall} !== 3'b001) begin
                failures++;
                $display("FAIL to_wait%0d: got fault/valid/stall=%b expected 001", c, {mem_fault, mem_valid_out, mem_stall});
            end else if (c == 4 && {mem_fault, mem_valid_out, mem_stall} !== 3'b110) begin
                failures++;
                $display("FAIL to_expire: got fault/valid/stall=%b expected 110", {mem_fault, mem_valid_out, mem_stall});
            end
        end
        checks++;
        if (req_cycles != 4) begin
            failures++;
            $display("FAIL to_req_cycles: got %0d expected 4", req_cycles);
        end
        step();
        set_inst(1'b1, 1'b1, 1'b0, 32'h0000_4004, 32'h0, 3'b010);
        checks++;
        if (proc2mem_req !== 1'b0 || mem_stall !== 1'b1 || mem_fault !== 1'b0) begin
            failures++;
            $display("FAIL to_next_accept: got req=%b stall=%b fault=%b expected 0 1 0", proc2mem_req, mem_stall, mem_fault);
        end
        step();
        checks++;
        if (proc2mem_req !== 1'b1 || proc2mem_addr !== 32'h0000_4004) begin
            failures++;
            $display("FAIL to_next_req: got req=%b addr=%h expected 1 00004004", proc2mem_req, proc2mem_addr);
        end
        mem2proc_ack = 1'b1;
        mem2proc_data = 32'h0;
        step();
        mem2proc_ack = 1'b0;
        set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    task automatic test_reset_mid();
        step();
        set_inst(1'b1, 1'b0, 1'b1, 32'h0000_7000, 32'hCAFE_F00D, 3'b010);
        step();
        rst = 1'b1;
        mem2proc_ack = 1'b1;
        step();
        rst = 1'b0;
        mem2proc_ack = 1'b0;
        set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        checks++;
        if (proc2mem_req !== 1'b0 || proc2mem_addr !== 32'h0 || proc2mem_be !== 4'h0 || proc2mem_data !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_regs: got req=%b addr=%h be=%b data=%h expected all 0",
                     proc2mem_req, proc2mem_addr, proc2mem_be, proc2mem_data);
        end
        checks++;
        if (mem_valid_out !== 1'b0 || mem_fault !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_valid: got valid=%b fault=%b expected 0 0", mem_valid_out, mem_fault);
        end
        // IDLE is shown by an immediate pass-through.
        set_inst(1'b1, 1'b0, 1'b0, 32'h0000_BEEF, 32'h0, 3'b000);
        checks++;
        if (mem_result_out !== 32'h0000_BEEF || mem_stall !== 1'b0 || mem_valid_out !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_idle: got result=%h stall=%b valid=%b expected 0000beef 0 1",
                     mem_result_out, mem_stall, mem_valid_out);
        end
        set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_lb();
        test_stores();
        test_load_formats();
        test_bad_access();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
